// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the instruction-fetch stage
package cpu_pkg;

  // Default datapath width for PC, instruction word and cycle counter
  localparam int BUS_WIDTH_DEFAULT = 32;

  // All-zero word: inserted as the bubble on flushes and used as the end-of-program marker
  localparam int unsigned NOP_INSTR = 0;

  // Fetch sequencer states; 2'b11 is illegal and recovers to ST_RUN with a flush
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_STALL = 2'b01,
    ST_HALT  = 2'b10
  } fetch_state_e;

  // Next-PC source select for fetch_pc_reg
  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_LOAD = 2'b10
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - fetch PC register with hold/increment/load select
module fetch_pc_reg
  import cpu_pkg::*;
#(
  parameter int                 W        = BUS_WIDTH_DEFAULT,
  parameter logic [W-1:0]       RESET_PC = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  pc_sel_e      sel,
  input  logic [W-1:0] load_pc,
  output logic [W-1:0] pc
);

  // PC update; increment wraps modulo 2^W with no flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_LOAD: pc <= load_pc;
        PC_INC:  pc <= pc + W'(1);
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch PC, IF/ID register and cycle counter sequencer; FETCH_CTRL_WRAP_EN makes a zero word loop back to RESET_PC instead of halting
module fetch_controller
  import cpu_pkg::*;
#(
  parameter int                   BUS_WIDTH = BUS_WIDTH_DEFAULT,
  parameter logic [BUS_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 STALL,
  input  logic                 REDIRECT,
  input  logic [BUS_WIDTH-1:0] REDIRECT_PC,
  input  logic [BUS_WIDTH-1:0] Instr,
  output logic [BUS_WIDTH-1:0] F_PC,
  output logic [BUS_WIDTH-1:0] InstrD,
  output logic                 ValidD,
  output logic                 Halted,
  output logic [BUS_WIDTH-1:0] CLK_cycle
);

  localparam logic [BUS_WIDTH-1:0] NOP_W = BUS_WIDTH'(NOP_INSTR);

  fetch_state_e         state;
  pc_sel_e              pc_sel;
  logic [BUS_WIDTH-1:0] load_pc;
  logic                 is_zero;

  assign is_zero = (Instr == NOP_W);

  // Next-PC select, following redirect > stall > zero word > advance
  always_comb begin
    pc_sel  = PC_HOLD;
    load_pc = REDIRECT_PC;
    if (REDIRECT) begin
      pc_sel = PC_LOAD;
    end else begin
      case (state)
        ST_RUN, ST_STALL: begin
          if (STALL) begin
            pc_sel = PC_HOLD;
          end else if (is_zero) begin
`ifdef FETCH_CTRL_WRAP_EN
            pc_sel  = PC_LOAD;
            load_pc = RESET_PC;
`else
            pc_sel  = PC_HOLD;
`endif
          end else begin
            pc_sel = PC_INC;
          end
        end
        default: pc_sel = PC_HOLD;
      endcase
    end
  end

  fetch_pc_reg #(
    .W        (BUS_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .CLK     (CLK),
    .RST     (RST),
    .sel     (pc_sel),
    .load_pc (load_pc),
    .pc      (F_PC)
  );

`ifdef FETCH_CTRL_WRAP_EN
  assign Halted = 1'b0;
`endif

  // Sequencer state, IF/ID register, halt flag and free-running cycle counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_RUN;
      InstrD    <= NOP_W;
      ValidD    <= 1'b0;
      CLK_cycle <= '0;
`ifndef FETCH_CTRL_WRAP_EN
      Halted    <= 1'b0;
`endif
    end else begin
      CLK_cycle <= CLK_cycle + BUS_WIDTH'(1);
      if (REDIRECT) begin
        state  <= ST_RUN;
        InstrD <= NOP_W;
        ValidD <= 1'b0;
`ifndef FETCH_CTRL_WRAP_EN
        Halted <= 1'b0;
`endif
      end else begin
        case (state)
          ST_RUN, ST_STALL: begin
            if (STALL) begin
              state <= ST_STALL;
            end else if (is_zero) begin
              InstrD <= NOP_W;
              ValidD <= 1'b0;
`ifdef FETCH_CTRL_WRAP_EN
              state  <= ST_RUN;
`else
              state  <= ST_HALT;
              Halted <= 1'b1;
`endif
            end else begin
              state  <= ST_RUN;
              InstrD <= Instr;
              ValidD <= 1'b1;
            end
          end
`ifndef FETCH_CTRL_WRAP_EN
          ST_HALT: begin
            InstrD <= NOP_W;
            ValidD <= 1'b0;
            Halted <= 1'b1;
          end
`endif
          default: begin
            state  <= ST_RUN;
            InstrD <= NOP_W;
            ValidD <= 1'b0;
`ifndef FETCH_CTRL_WRAP_EN
            Halted <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller
module tb_fetch_controller;

  logic        CLK = 1'b0;
  logic        RST, STALL, REDIRECT;
  logic [31:0] REDIRECT_PC, Instr, F_PC, InstrD, CLK_cycle;
  logic        ValidD, Halted;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  assign Instr = mem[F_PC[7:0]];

  fetch_controller #(.BUS_WIDTH(32), .RESET_PC(32'h0)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .STALL       (STALL),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .Instr       (Instr),
    .F_PC        (F_PC),
    .InstrD      (InstrD),
    .ValidD      (ValidD),
    .Halted      (Halted),
    .CLK_cycle   (CLK_cycle)
  );

  typedef struct {
    bit          rst, stall, redir;
    logic [31:0] rpc;
    logic [31:0] e_pc, e_instr;
    bit          e_valid, e_halt;
    logic [31:0] e_cyc;
  } vec_t;

  vec_t tbl[$];

  // Reference state: the architectural view only (PC, IF/ID, halt flag, cycles)
  logic [31:0] m_pc, m_instr, m_cyc;
  bit          m_valid, m_halt;

  task automatic add(bit rst, bit stall, bit redir, logic [31:0] rpc,
                     logic [31:0] pc, logic [31:0] ins, bit v, bit h, logic [31:0] cyc);
    vec_t t;
    t.rst = rst; t.stall = stall; t.redir = redir; t.rpc = rpc;
    t.e_pc = pc; t.e_instr = ins; t.e_valid = v; t.e_halt = h; t.e_cyc = cyc;
    tbl.push_back(t);
  endtask

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(bit rst, bit stall, bit redir, logic [31:0] rpc);
    @(negedge CLK);
    RST = rst; STALL = stall; REDIRECT = redir; REDIRECT_PC = rpc;
  endtask

  task automatic model_edge(bit rst, bit stall, bit redir, logic [31:0] rpc);
    logic [31:0] w;
    w = mem[m_pc[7:0]];
    if (rst) begin
      m_pc = 0; m_instr = 0; m_valid = 0; m_halt = 0; m_cyc = 0;
    end else begin
      m_cyc = m_cyc + 1;
      if (redir) begin
        m_pc = rpc; m_instr = 0; m_valid = 0; m_halt = 0;
      end else if (m_halt) begin
        m_instr = 0; m_valid = 0;
      end else if (stall) begin
        m_instr = m_instr;
      end else if (w == 0) begin
        m_instr = 0; m_valid = 0;
`ifdef FETCH_CTRL_WRAP_EN
        m_pc = 0;
`else
        m_halt = 1;
`endif
      end else begin
        m_instr = w; m_valid = 1; m_pc = m_pc + 1;
      end
    end
  endtask

  initial begin
    RST = 1; STALL = 0; REDIRECT = 0; REDIRECT_PC = 0;
    foreach (mem[i]) mem[i] = 32'h1000 + i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h0;
    mem[8'h40] = 32'h4040; mem[8'h41] = 32'h4141; mem[8'hFF] = 32'hFFAA;

    //   rst st rd rpc            pc            instr      v  h  cyc
    add(1, 0, 0, 0,             0,            0,         0, 0, 0);
    add(1, 0, 0, 0,             0,            0,         0, 0, 0);
    add(0, 0, 0, 0,             1,            32'h11,    1, 0, 1);
    add(0, 0, 0, 0,             2,            32'h22,    1, 0, 2);
    add(0, 1, 0, 0,             2,            32'h22,    1, 0, 3);
    add(0, 1, 0, 0,             2,            32'h22,    1, 0, 4);
    add(0, 1, 0, 0,             2,            32'h22,    1, 0, 5);
    add(0, 0, 0, 0,             3,            32'h33,    1, 0, 6);
`ifdef FETCH_CTRL_WRAP_EN
    add(0, 0, 0, 0,             0,            0,         0, 0, 7);
    add(0, 1, 0, 0,             0,            0,         0, 0, 8);
    add(0, 0, 0, 0,             1,            32'h11,    1, 0, 9);
    add(0, 1, 0, 0,             1,            32'h11,    1, 0, 10);
    add(0, 0, 0, 0,             2,            32'h22,    1, 0, 11);
`else
    add(0, 0, 0, 0,             3,            0,         0, 1, 7);
    add(0, 1, 0, 0,             3,            0,         0, 1, 8);
    add(0, 0, 0, 0,             3,            0,         0, 1, 9);
    add(0, 1, 0, 0,             3,            0,         0, 1, 10);
    add(0, 0, 0, 0,             3,            0,         0, 1, 11);
`endif
    add(0, 1, 1, 32'h40,        32'h40,       0,         0, 0, 12);
    add(0, 0, 0, 0,             32'h41,       32'h4040,  1, 0, 13);
    add(0, 1, 1, 32'hFFFFFFFF,  32'hFFFFFFFF, 0,         0, 0, 14);
    add(0, 0, 0, 0,             0,            32'hFFAA,  1, 0, 15);
    add(0, 0, 0, 0,             1,            32'h11,    1, 0, 16);
    add(0, 1, 0, 0,             1,            32'h11,    1, 0, 17);
    add(1, 1, 0, 0,             0,            0,         0, 0, 0);
    add(0, 0, 0, 0,             1,            32'h11,    1, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].rpc);
      @(posedge CLK); #1;
      check("tbl F_PC",      i, F_PC,            tbl[i].e_pc);
      check("tbl InstrD",    i, InstrD,          tbl[i].e_instr);
      check("tbl ValidD",    i, 32'(ValidD),     32'(tbl[i].e_valid));
      check("tbl Halted",    i, 32'(Halted),     32'(tbl[i].e_halt));
      check("tbl CLK_cycle", i, CLK_cycle,       tbl[i].e_cyc);
    end

    // Halt then redirect to 0 from within HALT while stalling
    drive(0, 1, 1, 32'h3);
    @(posedge CLK); #1;
    drive(0, 0, 0, 0);
    @(posedge CLK); #1;
    check("halt entry F_PC", 0, F_PC, `ifdef FETCH_CTRL_WRAP_EN 32'h0 `else 32'h3 `endif);
    check("halt entry Halted", 0, 32'(Halted), `ifdef FETCH_CTRL_WRAP_EN 32'h0 `else 32'h1 `endif);
    drive(0, 1, 1, 32'h0);
    @(posedge CLK); #1;
    check("halt exit Halted", 0, 32'(Halted), 32'h0);
    check("halt exit F_PC",   0, F_PC,        32'h0);
    drive(0, 0, 0, 0);
    @(posedge CLK); #1;
    check("halt exit InstrD", 0, InstrD, 32'h11);

    // Randomized run against the reference model
    foreach (mem[i]) mem[i] = ($urandom_range(0, 99) < 12) ? 32'h0 : $urandom;
    drive(1, 0, 0, 0);
    model_edge(1, 0, 0, 0);
    @(posedge CLK); #1;
    for (int c = 0; c < 600; c++) begin
      bit          r, s, d;
      logic [31:0] p;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 30);
      d = ($urandom_range(0, 99) < 10);
      case ($urandom_range(0, 2))
        0:       p = 32'h0;
        1:       p = 32'hFFFFFFF0 + $urandom_range(0, 15);
        default: p = $urandom;
      endcase
      drive(r, s, d, p);
      model_edge(r, s, d, p);
      @(posedge CLK); #1;
      check("rnd F_PC",      c, F_PC,        m_pc);
      check("rnd InstrD",    c, InstrD,      m_instr);
      check("rnd ValidD",    c, 32'(ValidD), 32'(m_valid));
      check("rnd Halted",    c, 32'(Halted), 32'(m_halt));
      check("rnd CLK_cycle", c, CLK_cycle,   m_cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
